// File: rtl/fp_result_mailbox.sv
// fp_result_mailbox
//   Memory-mapped result mailbox on the ARM core data bus. Stores to DATA are
//   buffered in a small FIFO. Each stored word is compared against the EXPECT
//   register, and the result is recorded in sticky pass/fail flags. Buffered
//   words drain through a valid/ready port.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   MemWrite   in   core store strobe
//   DataAdr    in   core data address (byte)
//   WriteData  in   core store data
//   ReadData   out  combinational load data (0 outside the window)
//   Sel        out  1 when DataAdr is an aligned address inside the window
//   out_valid  out  FIFO head available
//   out_data   out  FIFO head word (0 when empty)
//   out_ready  in   consumer accepts the head
//   pass       out  sticky: a pushed word matched EXPECT
//   fail       out  sticky: a pushed word mismatched EXPECT
//
// Register window (byte offsets from BASE_ADDR)
//   0x0 DATA   W: push word, R: 0
//   0x4 STATUS R: {count[15:8], fail[4], pass[3], overflow[2], full[1], empty[0]}
//              W: WriteData[0]=1 clears overflow/pass/fail
//   0x8 EXPECT R/W compare value
//   0xC HEAD   R: FIFO head or 0
module fp_result_mailbox #(
  parameter logic [31:0] BASE_ADDR   = 32'd160,
  parameter int          DEPTH       = 4,
  parameter logic [31:0] EXPECT_INIT = 32'h4202a40b
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Sel,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        pass,
  output logic        fail
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    OFF_DATA   = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_EXPECT = 2'd2,
    OFF_HEAD   = 2'd3
  } reg_off_e;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_pass;
  logic          r_fail;
  logic [31:0]   r_expect;

  reg_off_e      w_off;
  logic          w_sel;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_clear;
  logic          w_expect_wr;
  logic          w_match;
  logic [31:0]   w_head;
  logic [31:0]   w_status;

  // Misaligned addresses inside the window decode as "not selected", so
  // they neither write nor read anything.
  assign w_sel = (DataAdr[31:4] == BASE_ADDR[31:4]) && (DataAdr[1:0] == 2'b00);
  assign w_off = reg_off_e'(DataAdr[3:2]);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && out_ready;

  assign w_push_req  = MemWrite && w_sel && (w_off == OFF_DATA);
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign w_push_ok   = w_push_req && (!w_full || w_pop);
  assign w_clear     = MemWrite && w_sel && (w_off == OFF_STATUS) && WriteData[0];
  assign w_expect_wr = MemWrite && w_sel && (w_off == OFF_EXPECT);
  assign w_match     = (WriteData == r_expect);

  assign w_head   = w_empty ? 32'd0 : r_mem[r_rptr];
  assign w_status = {16'd0, 8'(r_count), 3'd0, r_fail, r_pass, r_overflow,
                     w_full, w_empty};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_expect   <= EXPECT_INIT;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;

      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;

      if (w_expect_wr) r_expect <= WriteData;

      // Clear and push are mutually exclusive (one bus address per cycle).
      if (w_clear) begin
        r_overflow <= 1'b0;
        r_pass     <= 1'b0;
        r_fail     <= 1'b0;
      end else if (w_push_req) begin
        if (!w_push_ok) r_overflow <= 1'b1;
        if (w_match)    r_pass     <= 1'b1;
        else            r_fail     <= 1'b1;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; pointers and count define
  // which entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) r_mem[r_wptr] <= WriteData;
  end

  // NOTE: default assigned first so no path through the case infers a latch.
  always_comb begin
    ReadData = 32'd0;
    if (w_sel) begin
      case (w_off)
        OFF_DATA:   ReadData = 32'd0;
        OFF_STATUS: ReadData = w_status;
        OFF_EXPECT: ReadData = r_expect;
        OFF_HEAD:   ReadData = w_head;
        default:    ReadData = 32'd0;
      endcase
    end
  end

  assign Sel       = w_sel;
  assign out_valid = !w_empty;
  assign out_data  = w_head;
  assign pass      = r_pass;
  assign fail      = r_fail;

endmodule

// File: tb/tb_fp_result_mailbox.sv
// Directed testbench for fp_result_mailbox (BASE_ADDR=160, DEPTH=4).
module tb_fp_result_mailbox;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Sel;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        pass;
  logic        fail;

  int n_pass  = 0;
  int n_total = 0;

  fp_result_mailbox dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Sel       (Sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .pass      (pass),
    .fail      (fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemWrite  = 1'b0;
    DataAdr   = 32'd0;
    WriteData = 32'd0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAdr   = addr;
    WriteData = data;
    tick();
    idle();
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    MemWrite = 1'b0;
    DataAdr  = addr;
    #1;
    data = ReadData;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    reset     = 1'b1;
    out_ready = 1'b0;
    idle();
    tick();

    // Reset state
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_pass",  32'(pass), 32'd0);
    check("rst_fail",  32'(fail), 32'd0);
    rd(32'd164, v); check("rst_status", v, 32'h0000_0001);
    rd(32'd168, v); check("rst_expect", v, 32'h4202a40b);
    rd(32'd160, v); check("data_read_zero", v, 32'd0);

    // Matching push
    wr(32'd160, 32'h4202a40b);
    check("match_valid", 32'(out_valid), 32'd1);
    check("match_data",  out_data, 32'h4202a40b);
    check("match_pass",  32'(pass), 32'd1);
    check("match_fail",  32'(fail), 32'd0);
    rd(32'd164, v); check("match_status", v, 32'h0000_0108);

    // Mismatching push, then sticky clear
    do_reset();
    wr(32'd160, 32'h4202a40c);
    check("mis_fail", 32'(fail), 32'd1);
    check("mis_pass", 32'(pass), 32'd0);
    rd(32'd164, v); check("mis_status", v, 32'h0000_0110);
    wr(32'd164, 32'h1);
    check("clr_pass", 32'(pass), 32'd0);
    check("clr_fail", 32'(fail), 32'd0);
    rd(32'd164, v); check("clr_status", v, 32'h0000_0100);

    // Overflow: five pushes into a 4-deep FIFO, then drain
    do_reset();
    for (int k = 1; k <= 5; k++) wr(32'd160, 32'(k));
    // count=4, fail, overflow, full
    rd(32'd164, v); check("ovf_status", v, 32'h0000_0416);
    idle();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain_%0d", k), out_data, 32'(k));
      tick();
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Push and pop together while full
    do_reset();
    for (int k = 1; k <= 4; k++) wr(32'd160, 32'(k));
    out_ready = 1'b1;
    MemWrite  = 1'b1;
    DataAdr   = 32'd160;
    WriteData = 32'hA;
    #1;
    check("pp_head_before", out_data, 32'd1);
    tick();
    idle();
    out_ready = 1'b0;
    // count=4, fail, no overflow, full
    rd(32'd164, v); check("pp_status", v, 32'h0000_0412);
    idle();
    out_ready = 1'b1;
    check("pp_out_2", out_data, 32'd2); tick();
    check("pp_out_3", out_data, 32'd3); tick();
    check("pp_out_4", out_data, 32'd4); tick();
    check("pp_out_A", out_data, 32'hA); tick();
    check("pp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // EXPECT write and HEAD read
    do_reset();
    wr(32'd168, 32'h3f800000);
    rd(32'd168, v); check("exp_read", v, 32'h3f800000);
    wr(32'd160, 32'h3f800000);
    check("exp_pass", 32'(pass), 32'd1);
    check("exp_fail", 32'(fail), 32'd0);
    rd(32'd172, v); check("head_read", v, 32'h3f800000);

    // Out-of-window and misaligned stores leave state unchanged
    MemWrite = 1'b1; DataAdr = 32'd176; WriteData = 32'hDEAD_0001;
    #1;
    check("oow_sel",  32'(Sel), 32'd0);
    check("oow_read", ReadData, 32'd0);
    tick();
    MemWrite = 1'b1; DataAdr = 32'd162; WriteData = 32'hDEAD_0002;
    #1;
    check("mis_sel",  32'(Sel), 32'd0);
    check("mis_read", ReadData, 32'd0);
    tick();
    idle();
    rd(32'd164, v); check("ign_status", v, 32'h0000_0108);
    rd(32'd172, v); check("ign_head", v, 32'h3f800000);
    rd(32'd168, v); check("ign_expect", v, 32'h3f800000);

    // Reset with a push pending
    reset = 1'b1;
    MemWrite = 1'b1; DataAdr = 32'd160; WriteData = 32'h3f800000;
    tick();
    reset = 1'b0;
    idle();
    rd(32'd164, v); check("rstp_status", v, 32'h0000_0001);
    rd(32'd168, v); check("rstp_expect", v, 32'h4202a40b);
    check("rstp_valid", 32'(out_valid), 32'd0);
    check("rstp_pass",  32'(pass), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
